// File: rtl/adc_trigger_capture_if.sv
// adc_trigger_capture_if
//   Bundles the sample stream, capture control, trigger setup and read-back
//   signals of adc_trigger_capture.
//   master: drives samples and control (JTAG/debug side, testbench).
//   slave : the capture buffer itself.
//   Signals:
//     in_data/in_valid   sample word (N_CH signed codes) and its qualifier
//     arm/abort          capture start / cancel pulses
//     trig_mode          0 ext, 1 rising threshold, 2 immediate, 3 as 0
//     trig_ext           external trigger level
//     trig_chan          channel watched by the threshold trigger
//     trig_thresh        signed threshold
//     pre_trig           pre-trigger sample count, sampled on arm
//     rd_addr/rd_data    trigger-relative read index and registered word
//     trig_addr          physical address of the trigger sample
//     state_o/done       capture state and completion flag
interface adc_trigger_capture_if #(
  parameter int N_CH   = 18,
  parameter int N_BITS = 8,
  parameter int DEPTH  = 256
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0][N_BITS-1:0] in_data;
  logic                        in_valid;
  logic                        arm;
  logic                        abort;
  logic [1:0]                  trig_mode;
  logic                        trig_ext;
  logic [CH_W-1:0]             trig_chan;
  logic [N_BITS-1:0]           trig_thresh;
  logic [ADDR_W-1:0]           pre_trig;
  logic [ADDR_W-1:0]           rd_addr;
  logic [N_CH-1:0][N_BITS-1:0] rd_data;
  logic [ADDR_W-1:0]           trig_addr;
  logic [2:0]                  state_o;
  logic                        done;

  modport master (
    output in_data, in_valid, arm, abort, trig_mode, trig_ext, trig_chan,
           trig_thresh, pre_trig, rd_addr,
    input  rd_data, trig_addr, state_o, done
  );

  modport slave (
    input  in_data, in_valid, arm, abort, trig_mode, trig_ext, trig_chan,
           trig_thresh, pre_trig, rd_addr,
    output rd_data, trig_addr, state_o, done
  );
endinterface

// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture
//   Multi-channel ADC-code snapshot buffer with a circular pre-trigger window
//   and selectable trigger source (external, rising threshold crossing on one
//   channel, or immediate). After the trigger, DEPTH-pre_eff-1 further samples
//   are stored, then the buffer freezes in DONE for trigger-relative read-back.
//   Ports:
//     clk  capture/read clock (clk_adc)
//     rst  asynchronous active-high reset
//     bus  adc_trigger_capture_if.slave (samples, control, read-back, status)
module adc_trigger_capture #(
  parameter int N_CH   = 18,
  parameter int N_BITS = 8,
  parameter int DEPTH  = 256
) (
  input logic                  clk,
  input logic                  rst,
  adc_trigger_capture_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef logic [N_CH-1:0][N_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          wr_ptr;
  logic [ADDR_W-1:0]          pre_eff;
  logic [ADDR_W-1:0]          post_cnt;
  logic [ADDR_W-1:0]          trig_addr_q;
  logic                       done_q;
  logic                       prev_valid;
  logic signed [N_BITS-1:0]   prev_code;
  logic signed [N_BITS-1:0]   cur_code;
  logic signed [N_BITS-1:0]   thresh;
  logic                       trig_hit;
  logic                       we;
  logic [ADDR_W-1:0]          rd_phys;
  word_t                      rd_q;
  word_t                      mem [DEPTH];

  // Writes happen only while capturing; abort suppresses that cycle's sample.
  always_comb begin
    we = 1'b0;
    if (bus.in_valid && !bus.abort &&
        (state == S_PRE || state == S_WAIT || state == S_POST))
      we = 1'b1;
  end

  always_comb begin
    cur_code = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      if (bus.trig_chan == CH_W'(c))
        cur_code = bus.in_data[c];
    thresh = bus.trig_thresh;
    case (bus.trig_mode)
      2'd1:    trig_hit = prev_valid && (prev_code < thresh) && (cur_code >= thresh);
      2'd2:    trig_hit = 1'b1;
      default: trig_hit = bus.trig_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      pre_eff     <= '0;
      post_cnt    <= '0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
      prev_valid  <= 1'b0;
      prev_code   <= '0;
    end else if (bus.abort) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            // pre_trig is ADDR_W wide, so it can never exceed DEPTH-1.
            pre_eff    <= bus.pre_trig;
            wr_ptr     <= '0;
            prev_valid <= 1'b0;
            done_q     <= 1'b0;
            state      <= (bus.pre_trig != '0) ? S_PRE : S_WAIT;
          end
        end
        S_PRE: begin
          // wr_ptr counts PRE samples; the window never wraps before WAIT.
          if (bus.in_valid) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == pre_eff - ADDR_W'(1))
              state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.in_valid) begin
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            prev_code  <= cur_code;
            prev_valid <= 1'b1;
            if (trig_hit) begin
              trig_addr_q <= wr_ptr;
              post_cnt    <= LAST_ADDR - pre_eff;
              if (pre_eff == LAST_ADDR) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (bus.in_valid) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= bus.in_data;
  end

  // Logical index 0 is the oldest kept sample, pre_eff entries before trigger.
  always_comb rd_phys = trig_addr_q - pre_eff + bus.rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_q <= '0;
    else
      rd_q <= mem[rd_phys];
  end

  assign bus.rd_data   = rd_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.state_o   = state;
  assign bus.done      = done_q;
endmodule
